// File: rtl/frame_writer.sv
// Pixel-stream to framebuffer writer: buffers (X,Y,colour) in a small FIFO,
// clips off-screen pixels and issues one-cycle RAM writes when the RAM is free.
module frame_writer #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         CounterX,
  input  logic [7:0]         CounterY,
  input  logic [COLOR_W-1:0] color,
  input  logic               valid,
  output logic               ready,
  input  logic               mem_busy,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_wren,
  output logic               frame_done,
  output logic [7:0]         drop_count
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  logic [ADDR_W-1:0]  fifo_addr_q  [DEPTH];
  logic [COLOR_W-1:0] fifo_color_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [COLOR_W-1:0] mem_data_q;
  logic               mem_wren_q, frame_done_q;
  logic [7:0]         drop_q;

  logic              in_range, push, store, pop;
  logic [ADDR_W-1:0] addr_in;

  // ready deliberately ignores valid and is forced low while reset is high
  assign ready    = !reset && (count_q < (PTR_W+1)'(DEPTH));
  assign push     = valid && ready;
  assign in_range = (32'(CounterX) < H_RES) && (32'(CounterY) < V_RES);
  assign store    = push && in_range;
  assign pop      = (count_q != '0) && !mem_busy;
  assign addr_in  = ADDR_W'(CounterY) * ADDR_W'(H_RES) + ADDR_W'(CounterX);

  always_ff @(posedge clk) begin
    if (store) begin
      fifo_addr_q[wr_ptr_q]  <= addr_in;
      fifo_color_q[wr_ptr_q] <= color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wren_q   <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        mem_addr_q <= fifo_addr_q[rd_ptr_q];
        mem_data_q <= fifo_color_q[rd_ptr_q];
      end
      mem_wren_q   <= pop;
      frame_done_q <= pop && (fifo_addr_q[rd_ptr_q] == LAST_ADDR);
      case ({store, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && !in_range && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_wren   = mem_wren_q;
  assign frame_done = frame_done_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: directed scenarios plus randomized pixels, checked
// against a queue of expected framebuffer writes derived from X/Y arithmetic.
module tb_frame_writer;
  localparam int LAST = 160 * 120 - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  CounterX = '0, CounterY = '0;
  logic [11:0] color = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        mem_busy = 1'b0;
  logic [14:0] mem_addr;
  logic [11:0] mem_data;
  logic        mem_wren, frame_done;
  logic [7:0]  drop_count;

  frame_writer dut (
    .clk(clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .color(color), .valid(valid), .ready(ready), .mem_busy(mem_busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .frame_done(frame_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  int drop_exp = 0;
  bit rand_busy = 1'b0;
  logic [26:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every accepted on-screen pixel becomes one write, in order
  always @(negedge clk) begin
    if (mem_wren) begin
      wr_cnt++;
      if (frame_done) fd_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[26:12]));
        chk("wr_data", 32'(mem_data), 32'(e[11:0]));
        chk("wr_frame_done", 32'(frame_done), 32'(int'(e[26:12]) == LAST));
      end
    end else if (frame_done) begin
      chk("frame_done_without_write", 32'(frame_done), 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input int x, input int y, input int c);
    bit done = 1'b0;
    CounterX = 8'(x); CounterY = 8'(y); color = 12'(c); valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (rand_busy) mem_busy = ($urandom_range(0, 3) == 0);
      #1;
      if (ready) begin
        if (x < 160 && y < 120) exp_q.push_back({15'(y * 160 + x), 12'(c)});
        else if (drop_exp < 255) drop_exp++;
        done = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int i = 0;
    valid = 1'b0;
    mem_busy = 1'b0;
    while (exp_q.size() != 0 && i < 500) begin @(negedge clk); i++; end
    repeat (3) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drop_count", 32'(drop_count), 32'(drop_exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; valid = 1'b0;
    #1 chk("ready_in_reset", 32'(ready), 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    drop_exp = 0;
    #1 chk("ready_after_reset", 32'(ready), 32'd1);
    chk("drop_after_reset", 32'(drop_count), 32'd0);
  endtask

  initial begin
    int w0, f0;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single pixel with latency check
    w0 = wr_cnt;
    send(0, 0, 12'hFFF);
    valid = 1'b0;
    chk("lat_no_write_yet", 32'(mem_wren), 32'd0);
    @(negedge clk);
    chk("lat_wren", 32'(mem_wren), 32'd1);
    @(negedge clk);
    chk("lat_one_cycle", 32'(mem_wren), 32'd0);
    chk("single_count", 32'(wr_cnt - w0), 32'd1);

    // last pixel
    f0 = fd_cnt;
    send(159, 119, 12'h0A5);
    drain();
    chk("last_frame_done", 32'(fd_cnt - f0), 32'd1);

    // clipping
    w0 = wr_cnt;
    send(160, 0, 12'h111);
    send(0, 120, 12'h222);
    send(5, 2, 12'h333);
    drain();
    chk("clip_drop", 32'(drop_count), 32'd2);
    chk("clip_writes", 32'(wr_cnt - w0), 32'd1);

    // backpressure
    w0 = wr_cnt;
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(10 + i, 3, 12'h400 + 12'(i));
    #1 chk("bp_ready_low", 32'(ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("bp_no_writes", 32'(wr_cnt - w0), 32'd0);
    mem_busy = 1'b0;
    for (int i = 4; i < 6; i++) send(10 + i, 3, 12'h400 + 12'(i));
    drain();
    chk("bp_writes", 32'(wr_cnt - w0), 32'd6);

    // full frame sweep
    do_reset();
    w0 = wr_cnt; f0 = fd_cnt;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        send(x, y, (x * 7 + y * 13) & 12'hFFF);
    drain();
    chk("frame_writes", 32'(wr_cnt - w0), 32'd19200);
    chk("frame_done_once", 32'(fd_cnt - f0), 32'd1);
    chk("frame_drop", 32'(drop_count), 32'd0);

    // reset mid-operation
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) send(i, 1, 12'h700 + 12'(i));
    valid = 1'b0;
    w0 = wr_cnt;
    do_reset();
    mem_busy = 1'b0;
    idle(10);
    chk("mid_reset_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("mid_reset_ready", 32'(ready), 32'd1);

    // randomized pixels, some off-screen, with random RAM contention
    rand_busy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send($urandom_range(0, 175), $urandom_range(0, 130), $urandom_range(0, 4095));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    rand_busy = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Downstream consumer of the background/clear scan generator's pixel stream (X 0..159, Y 0..119, 12-bit colour).
- Buffers incoming pixels in a small FIFO.
- Converts each (X, Y) pair to a linear framebuffer address and issues single-cycle writes to the 160x120 framebuffer RAM, stalling while the display side holds the RAM.
- Its ready output drives the upstream generator's lock (advance-enable) input.

Parameters:
- H_RES, 160, pixels per line; also the address row stride.
- V_RES, 120, lines per frame.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- ADDR_W, 15, framebuffer address width.
- COLOR_W, 12, colour width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- CounterX  input  8  pixel X from upstream.
- CounterY  input  8  pixel Y from upstream.
- color  input  COLOR_W  pixel colour from upstream.
- valid  input  1  upstream pixel present this cycle.
- ready  output  1  block can accept a pixel; wired to upstream lock.
- mem_busy  input  1  framebuffer port held by display side; no write may start.
- mem_addr  output  ADDR_W  framebuffer write address.
- mem_data  output  COLOR_W  framebuffer write data.
- mem_wren  output  1  framebuffer write strobe, one cycle per pixel.
- frame_done  output  1  one-cycle pulse on the write to the last pixel.
- drop_count  output  8  count of clipped pixels, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; occupancy = 0.
  - ready = 0 during any cycle in which reset is high.
  - mem_wren = 0, mem_addr = 0, mem_data = 0, frame_done = 0, drop_count = 0.
  - Reset mid-operation discards buffered pixels and any write in flight. No write occurs on the edge where reset is sampled.
- Handshake:
  - Transfer occurs on a rising edge where valid && ready.
  - ready = !reset && (occupancy < DEPTH). ready is combinational from registered occupancy only; it does not depend on valid.
- Clipping:
  - A transferred pixel with CounterX >= H_RES or CounterY >= V_RES completes the handshake but is not stored.
  - Each clipped pixel increments drop_count by 1; drop_count saturates at 255.
- Address arithmetic:
  - addr = CounterY*H_RES + CounterX, computed at the input and stored in the FIFO with the colour.
  - With default parameters: (Y<<7) + (Y<<5) + X, evaluated at ADDR_W bits.
  - Maximum address = 19199 (0x4AFF).
- Write stage:
  - A pop occurs on any edge where occupancy > 0 and mem_busy = 0.
  - On the popping edge, mem_addr and mem_data are registered from the FIFO head, and mem_wren = 1 for exactly the following cycle.
  - When no pop occurs, mem_wren = 0; mem_addr and mem_data hold their last values.
  - mem_busy is sampled only at pop decision. A write already launched completes regardless of mem_busy.
- Latency:
  - A pixel transferred at edge E0 into an empty FIFO with mem_busy low pops at E1. mem_wren is high during E1..E2.
  - Throughput is 1 pixel/cycle sustained while mem_busy is low.
- Simultaneous push and pop: occupancy is unchanged, and ready stays at its pre-edge value. At occupancy = DEPTH, ready = 0, so no push can occur, even if a pop happens on that edge.
- Ordering: strict FIFO order; no reordering or merging of duplicate addresses.
- frame_done: high in the same cycle as mem_wren when mem_addr = H_RES*V_RES-1; low otherwise.
- Wrap-around:
  - FIFO read/write pointers wrap modulo DEPTH.
  - The upstream X/Y wrap (159->0, 119->0) needs no special handling.

Test Plan:
- Single pixel: reset released, valid=1 for 1 cycle with X=0, Y=0, color=0xFFF -> two edges later mem_wren=1 for one cycle, mem_addr=0, mem_data=0xFFF; frame_done=0.
- Last pixel: push X=159, Y=119, color=0x0A5 -> mem_addr=19199 (0x4AFF), mem_data=0x0A5, frame_done=1 in the same cycle as mem_wren.
- Clipping: push (160,0), then (0,120), then (5,2) -> drop_count=2; exactly one write with mem_addr=325.
- Backpressure: hold mem_busy=1, present 6 consecutive valid pixels -> ready drops after 4 accepts with no writes. Release mem_busy -> 4 consecutive writes in input order, then the remaining 2 are accepted and written.
- Full frame: upstream sweep with valid held high and mem_busy=0 -> 19200 writes at addresses 0..19199 in order, exactly one frame_done, drop_count=0.
- Reset mid-operation: fill FIFO with 3 entries under mem_busy=1, assert reset for 1 cycle, release mem_busy -> no writes occur, ready=0 during reset and 1 after, drop_count=0.
